// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the dual-slot pipeline sequencer: FSM encodings and register-index width.
package pipeline_ctrl_pkg;
  localparam int REG_IDX_W = 3;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;
endpackage

// File: rtl/hazard_match.sv
// Load-use detector: a load in ID/EX whose destination is read by either slot in IF/ID.
module hazard_match
  import pipeline_ctrl_pkg::*;
(
  input  logic                 i_memRead,
  input  logic                 i_regWrite,
  input  logic [REG_IDX_W-1:0] i_rd,
  input  logic [REG_IDX_W-1:0] i_alu_rm,
  input  logic [REG_IDX_W-1:0] i_alu_rn,
  input  logic [REG_IDX_W-1:0] i_mem_rn,
  input  logic [REG_IDX_W-1:0] i_mem_rd,
  input  logic                 i_alu_useRm,
  input  logic                 i_alu_useRn,
  input  logic                 i_mem_useRn,
  input  logic                 i_mem_useRd,
  output logic                 o_lu
);
  logic [3:0] w_hit;

  // r0 is an ordinary register here, so no zero-index exclusion.
  assign w_hit[0] = i_alu_useRm & (i_alu_rm == i_rd);
  assign w_hit[1] = i_alu_useRn & (i_alu_rn == i_rd);
  assign w_hit[2] = i_mem_useRn & (i_mem_rn == i_rd);
  assign w_hit[3] = i_mem_useRd & (i_mem_rd == i_rd);

  assign o_lu = i_memRead & i_regWrite & (|w_hit);
endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencer: load-use bubbles, branch/jump flushes and memory-wait freeze with timeout.
module hazard_stall_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [REG_IDX_W-1:0] p1_alu_rm,
  input  logic [REG_IDX_W-1:0] p1_alu_rn,
  input  logic [REG_IDX_W-1:0] p1_mem_rn,
  input  logic [REG_IDX_W-1:0] p1_mem_rd,
  input  logic                 p1_alu_useRm,
  input  logic                 p1_alu_useRn,
  input  logic                 p1_mem_useRn,
  input  logic                 p1_mem_useRd,
  input  logic                 p2_memRead,
  input  logic                 p2_mem_regWrite,
  input  logic [REG_IDX_W-1:0] p2_mem_rd,
  input  logic                 p2_isBranch,
  input  logic                 p2_isJump,
  input  logic                 branch_taken,
  input  logic                 p3_memAccess,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 p1_pipeline_regWrite,
  output logic                 p2_pipeline_regWrite,
  output logic                 p3_pipeline_regWrite,
  output logic                 p4_pipeline_regWrite,
  output logic                 p2_pipeline_stall,
  output logic                 IF_flush,
  output logic                 ID_flush,
  output logic                 mem_timeout,
  output logic [1:0]           state,
  output logic [CNT_WIDTH-1:0] loaduse_count,
  output logic [CNT_WIDTH-1:0] memwait_count,
  output logic [CNT_WIDTH-1:0] flush_count
);
  localparam logic [15:0]          TO_LIM  = 16'(MEM_TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t               r_state, w_nxt;
  logic [15:0]          r_wait;
  logic                 r_timeout;
  logic [CNT_WIDTH-1:0] r_lu_cnt, r_mw_cnt, r_fl_cnt;

  logic       w_lu, w_tk, w_mw;
  logic       w_run, w_mw_en, w_tk_en, w_lu_en, w_release;
  logic       w_pc, w_stall, w_iff, w_idf, w_abort;
  logic [3:0] w_en;
  logic       w_inc_lu, w_inc_mw, w_inc_fl, w_wait_ld, w_wait_inc;

  hazard_match u_match (
    .i_memRead   (p2_memRead),
    .i_regWrite  (p2_mem_regWrite),
    .i_rd        (p2_mem_rd),
    .i_alu_rm    (p1_alu_rm),
    .i_alu_rn    (p1_alu_rn),
    .i_mem_rn    (p1_mem_rn),
    .i_mem_rd    (p1_mem_rd),
    .i_alu_useRm (p1_alu_useRm),
    .i_alu_useRn (p1_alu_useRn),
    .i_mem_useRn (p1_mem_useRn),
    .i_mem_useRd (p1_mem_useRd),
    .o_lu        (w_lu)
  );

  assign w_tk      = p2_isJump | (p2_isBranch & branch_taken);
  assign w_mw      = p3_memAccess & ~mem_ready;
  assign w_release = mem_ready | (r_wait == TO_LIM);

  always_comb begin
    w_pc = 1'b1; w_en = 4'b1111; w_stall = 1'b0; w_iff = 1'b0; w_idf = 1'b0;
    w_nxt = ST_RUN; w_abort = 1'b0;
    w_inc_lu = 1'b0; w_inc_mw = 1'b0; w_inc_fl = 1'b0;
    w_wait_ld = 1'b0; w_wait_inc = 1'b0;
    w_run = 1'b0; w_mw_en = 1'b0; w_tk_en = 1'b0; w_lu_en = 1'b0;
    case (r_state)
      ST_RUN:   begin w_run = 1'b1; w_mw_en = 1'b1; w_tk_en = 1'b1; w_lu_en = 1'b1; end
      // IF/ID and ID/EX hold flushed bubbles, so only the memory wait can matter.
      ST_FLUSH: begin w_run = 1'b1; w_mw_en = 1'b1; end
      ST_MEM_WAIT: begin
        if (w_release) begin
          // An expired access is aborted and the pipeline advances as if memory answered.
          w_abort = ~mem_ready;
          w_run = 1'b1; w_tk_en = 1'b1; w_lu_en = 1'b1;
        end else begin
          w_pc = 1'b0; w_en = 4'b0000; w_nxt = ST_MEM_WAIT; w_wait_inc = 1'b1;
        end
      end
      default: w_nxt = ST_RUN;
    endcase
    if (w_run) begin
      if (w_mw_en && w_mw) begin
        w_pc = 1'b0; w_en = 4'b0000; w_nxt = ST_MEM_WAIT; w_wait_ld = 1'b1; w_inc_mw = 1'b1;
      end else if (w_tk_en && w_tk) begin
        w_iff = 1'b1; w_idf = 1'b1; w_nxt = ST_FLUSH; w_inc_fl = 1'b1;
      end else if (w_lu_en && w_lu) begin
        w_pc = 1'b0; w_en[0] = 1'b0; w_stall = 1'b1; w_inc_lu = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= ST_RUN;
      r_wait    <= '0;
      r_timeout <= 1'b0;
      r_lu_cnt  <= '0;
      r_mw_cnt  <= '0;
      r_fl_cnt  <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_wait_ld)       r_wait <= 16'd1;
      else if (w_wait_inc) r_wait <= r_wait + 16'd1;
      if (w_abort) r_timeout <= 1'b1;
      if (w_inc_lu && r_lu_cnt != CNT_MAX) r_lu_cnt <= r_lu_cnt + 1'b1;
      if (w_inc_mw && r_mw_cnt != CNT_MAX) r_mw_cnt <= r_mw_cnt + 1'b1;
      if (w_inc_fl && r_fl_cnt != CNT_MAX) r_fl_cnt <= r_fl_cnt + 1'b1;
    end
  end

  // Reset low forces a free-running pipeline regardless of state or events.
  assign pc_write             = ~reset | w_pc;
  assign p1_pipeline_regWrite = ~reset | w_en[0];
  assign p2_pipeline_regWrite = ~reset | w_en[1];
  assign p3_pipeline_regWrite = ~reset | w_en[2];
  assign p4_pipeline_regWrite = ~reset | w_en[3];
  assign p2_pipeline_stall    = reset & w_stall;
  assign IF_flush             = reset & w_iff;
  assign ID_flush             = reset & w_idf;
  assign mem_timeout          = r_timeout | (reset & w_abort);
  assign state                = r_state;
  assign loaduse_count        = r_lu_cnt;
  assign memwait_count        = r_mw_cnt;
  assign flush_count          = r_fl_cnt;
endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller with hand-computed expectations.
module tb_hazard_stall_controller;
  logic       clk = 1'b0, reset;
  logic [2:0] p1_alu_rm, p1_alu_rn, p1_mem_rn, p1_mem_rd, p2_mem_rd;
  logic       p1_alu_useRm, p1_alu_useRn, p1_mem_useRn, p1_mem_useRd;
  logic       p2_memRead, p2_mem_regWrite, p2_isBranch, p2_isJump, branch_taken;
  logic       p3_memAccess, mem_ready;
  logic       pc_write, p1_rw, p2_rw, p3_rw, p4_rw, stall, IF_flush, ID_flush, mem_timeout;
  logic [1:0] state;
  logic [15:0] lu_cnt, mw_cnt, fl_cnt;
  int n_chk = 0, n_pass = 0;

  hazard_stall_controller #(.MEM_TIMEOUT(5), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .p1_alu_rm(p1_alu_rm), .p1_alu_rn(p1_alu_rn), .p1_mem_rn(p1_mem_rn), .p1_mem_rd(p1_mem_rd),
    .p1_alu_useRm(p1_alu_useRm), .p1_alu_useRn(p1_alu_useRn),
    .p1_mem_useRn(p1_mem_useRn), .p1_mem_useRd(p1_mem_useRd),
    .p2_memRead(p2_memRead), .p2_mem_regWrite(p2_mem_regWrite), .p2_mem_rd(p2_mem_rd),
    .p2_isBranch(p2_isBranch), .p2_isJump(p2_isJump), .branch_taken(branch_taken),
    .p3_memAccess(p3_memAccess), .mem_ready(mem_ready),
    .pc_write(pc_write), .p1_pipeline_regWrite(p1_rw), .p2_pipeline_regWrite(p2_rw),
    .p3_pipeline_regWrite(p3_rw), .p4_pipeline_regWrite(p4_rw),
    .p2_pipeline_stall(stall), .IF_flush(IF_flush), .ID_flush(ID_flush),
    .mem_timeout(mem_timeout), .state(state),
    .loaduse_count(lu_cnt), .memwait_count(mw_cnt), .flush_count(fl_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clr();
    p1_alu_rm = 0; p1_alu_rn = 0; p1_mem_rn = 0; p1_mem_rd = 0; p2_mem_rd = 0;
    p1_alu_useRm = 0; p1_alu_useRn = 0; p1_mem_useRn = 0; p1_mem_useRd = 0;
    p2_memRead = 0; p2_mem_regWrite = 0; p2_isBranch = 0; p2_isJump = 0; branch_taken = 0;
    p3_memAccess = 0; mem_ready = 0;
  endtask

  task automatic set_field(input int f, input logic [2:0] v, input logic u);
    case (f)
      0: begin p1_alu_rm = v; p1_alu_useRm = u; end
      1: begin p1_alu_rn = v; p1_alu_useRn = u; end
      2: begin p1_mem_rn = v; p1_mem_useRn = u; end
      default: begin p1_mem_rd = v; p1_mem_useRd = u; end
    endcase
  endtask

  task automatic load_in_ex(input logic [2:0] rd);
    p2_memRead = 1; p2_mem_regWrite = 1; p2_mem_rd = rd;
  endtask

  initial begin
    // Reset, with a pending memory wait that must be masked.
    reset = 0; clr(); p3_memAccess = 1;
    #3;
    chk("rst_pc", pc_write, 1); chk("rst_p4rw", p4_rw, 1); chk("rst_stall", stall, 0);
    tick();
    chk("rst_state", state, 0); chk("rst_p1rw", p1_rw, 1); chk("rst_flush", IF_flush, 0);
    tick(); reset = 1; clr(); #3;
    chk("idle_state", state, 0); chk("idle_pc", pc_write, 1);
    chk("idle_rw", {p1_rw, p2_rw, p3_rw, p4_rw}, 4'b1111);
    chk("idle_cnt", {lu_cnt, mw_cnt}, 0); chk("idle_fl", fl_cnt, 0); chk("idle_to", mem_timeout, 0);

    // Load-use on alu_rn, same-cycle bubble.
    tick(); load_in_ex(3); set_field(1, 3, 1); #3;
    chk("lu_pc", pc_write, 0); chk("lu_p1rw", p1_rw, 0); chk("lu_stall", stall, 1);
    chk("lu_p2rw", p2_rw, 1);
    tick(); clr(); #3;
    chk("lu_after_pc", pc_write, 1); chk("lu_after_stall", stall, 0); chk("lu_cnt1", lu_cnt, 1);

    // Each field: match+use, mismatch+use, match without use.
    for (int f = 0; f < 4; f++) begin
      tick(); clr(); load_in_ex(5); set_field(f, 5, 1); #3;
      chk($sformatf("lu_hit_f%0d", f), stall, 1);
      tick(); clr(); load_in_ex(5); set_field(f, 4, 1); #3;
      chk($sformatf("lu_miss_f%0d", f), stall, 0);
      tick(); clr(); load_in_ex(5); set_field(f, 5, 0); #3;
      chk($sformatf("lu_nouse_f%0d", f), stall, 0);
    end
    tick(); clr(); load_in_ex(2); p2_mem_regWrite = 0; set_field(0, 2, 1); #3;
    chk("lu_norw", stall, 0);
    tick(); clr(); load_in_ex(0); set_field(3, 0, 1); #3;
    chk("lu_r0", stall, 1);
    tick(); clr(); #3;
    chk("lu_cnt6", lu_cnt, 6);

    // Taken branch beats a simultaneous load-use.
    tick(); clr(); load_in_ex(3); set_field(1, 3, 1); p2_isBranch = 1; branch_taken = 1; #3;
    chk("tk_iff", IF_flush, 1); chk("tk_idf", ID_flush, 1); chk("tk_stall", stall, 0);
    chk("tk_pc", pc_write, 1);
    tick(); clr(); load_in_ex(3); set_field(1, 3, 1); #3;
    chk("fl_state", state, 1); chk("fl_suppress", stall, 0); chk("fl_pc", pc_write, 1);
    chk("fl_noflush", IF_flush, 0);
    tick(); clr(); p2_isBranch = 1; #3;
    chk("nt_state", state, 0); chk("nt_iff", IF_flush, 0);
    chk("fl_cnt1", fl_cnt, 1); chk("lu_cnt_keep", lu_cnt, 6);

    // Memory wait, 4 stalled cycles then ready.
    tick(); clr(); p3_memAccess = 1; #3;
    chk("mw_pc", pc_write, 0); chk("mw_rw", {p1_rw, p2_rw, p3_rw, p4_rw}, 0); chk("mw_st0", state, 0);
    for (int i = 2; i <= 4; i++) begin
      tick(); #3;
      chk($sformatf("mw_hold%0d_pc", i), pc_write, 0); chk($sformatf("mw_hold%0d_st", i), state, 2);
    end
    tick(); mem_ready = 1; #3;
    chk("mw_rel_pc", pc_write, 1); chk("mw_rel_p4", p4_rw, 1); chk("mw_rel_st", state, 2);
    tick(); clr(); #3;
    chk("mw_done_st", state, 0); chk("mw_cnt1", mw_cnt, 1); chk("mw_no_to", mem_timeout, 0);

    // Timeout at wait count 5.
    tick(); clr(); p3_memAccess = 1; #3;
    chk("to_enter_pc", pc_write, 0);
    for (int i = 1; i <= 4; i++) begin
      tick(); #3;
      chk($sformatf("to_wait%0d_pc", i), pc_write, 0); chk($sformatf("to_wait%0d_to", i), mem_timeout, 0);
    end
    tick(); #3;
    chk("to_abort_pc", pc_write, 1); chk("to_abort_rw", p1_rw, 1); chk("to_abort_st", state, 2);
    chk("to_abort_flag", mem_timeout, 1);
    tick(); clr(); #3;
    chk("to_after_st", state, 0); chk("to_sticky", mem_timeout, 1); chk("mw_cnt2", mw_cnt, 2);
    tick(); #3;
    chk("to_sticky2", mem_timeout, 1);

    // Load-use saturation: 70000 stall cycles from a count of 6.
    tick(); clr(); load_in_ex(1); set_field(0, 1, 1);
    repeat (65528) tick();
    #2; chk("sat_pre", lu_cnt, 65534);
    repeat (4472) tick();
    #2; chk("sat_max", lu_cnt, 65535); chk("sat_stall", stall, 1);

    // Reset in the middle of a memory wait.
    tick(); clr(); p3_memAccess = 1;
    tick(); #3;
    chk("rmw_state", state, 2); chk("rmw_pc", pc_write, 0);
    reset = 0; #1;
    chk("rmw_forced_pc", pc_write, 1); chk("rmw_forced_rw", p4_rw, 1);
    tick(); reset = 1; clr(); #3;
    chk("rmw_st", state, 0); chk("rmw_to", mem_timeout, 0);
    chk("rmw_cnt", {lu_cnt, mw_cnt}, 0); chk("rmw_fl", fl_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Central pipeline sequencer for the dual-slot (ALU + MEM) 16-bit VLIW pipeline.
- Generates the per-stage write-enables, stall and flush controls consumed by the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC.
- Handles three events:
  - Load-use hazards: one-cycle bubble into ID/EX.
  - Taken branch or jump: flush IF/ID and ID/EX.
  - Multi-cycle data-memory access: full pipeline freeze via a ready handshake with timeout.
- Keeps stall statistics.

Parameters:
MEM_TIMEOUT, 255, max cycles in MEM_WAIT before the access is aborted (1..65535).
CNT_WIDTH, 16, width of stall/flush statistic counters.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-low reset (0 = reset on rising clk)
p1_alu_rm, p1_alu_rn, p1_mem_rn, p1_mem_rd  in  3 each  source register fields of the instruction pair in IF/ID
p1_alu_useRm, p1_alu_useRn, p1_mem_useRn, p1_mem_useRd  in  1 each  field is actually read (p1_mem_useRd=1 for stores)
p2_memRead  in  1  ID/EX MEM slot is a load
p2_mem_regWrite  in  1  ID/EX MEM slot writes a register
p2_mem_rd  in  3  load destination in ID/EX
p2_isBranch, p2_isJump  in  1  control-transfer in ID/EX
branch_taken  in  1  condition evaluated from p3 flags (valid with p2_isBranch)
p3_memAccess  in  1  EX/MEM holds a load or store
mem_ready  in  1  data memory completes access this cycle
pc_write  out  1  PC update enable
p1_pipeline_regWrite, p2_pipeline_regWrite, p3_pipeline_regWrite, p4_pipeline_regWrite  out  1 each  stage register enables
p2_pipeline_stall  out  1  load ID/EX with a bubble
IF_flush, ID_flush  out  1 each  clear IF/ID, clear ID/EX
mem_timeout  out  1  sticky: an access was aborted
state  out  2  FSM state (debug)
loaduse_count, memwait_count, flush_count  out  CNT_WIDTH each  saturating statistics

Behaviour:
- FSM states: RUN=0, FLUSH=1, MEM_WAIT=2. State 3 is illegal and goes to RUN next cycle.
- Reset (reset=0 at clk edge):
  - state=RUN, all counters=0, mem_timeout=0, wait counter=0.
  - While reset is low, outputs are forced to: pc_write=1, all regWrite=1, stall=0, flushes=0.
- Outputs are combinational from state and inputs (Mealy). The hazard must act in the same cycle.
- Load-use hazard (lu):
  - Condition: p2_memRead & p2_mem_regWrite & any(useX & (p1_X == p2_mem_rd)) over the four fields.
  - r0 is not special.
- Taken transfer (tk): p2_isJump | (p2_isBranch & branch_taken).
- Memory wait (mw): p3_memAccess & !mem_ready.
- RUN, priority mw > tk > lu:
  - mw:
    - Outputs: pc_write=0, all four regWrite=0, no flush, stall=0.
    - Next state MEM_WAIT; wait counter=1; memwait_count++.
  - tk:
    - Outputs: IF_flush=1, ID_flush=1, pc_write=1, all regWrite=1.
    - Next state FLUSH; flush_count++.
    - A simultaneous lu is ignored; that instruction is flushed.
  - lu:
    - Outputs: pc_write=0, p1_pipeline_regWrite=0, p2_pipeline_stall=1, others=1.
    - Stay in RUN; loaduse_count++.
    - The next cycle re-evaluates; the bubble in ID/EX clears the match.
  - none: all enables 1, no stall, no flush.
- FLUSH (exactly 1 cycle):
  - lu detection is suppressed (IF/ID content is a flushed bubble). tk cannot occur (ID/EX is a bubble).
  - mw is handled as in RUN and goes to MEM_WAIT. Otherwise all enables 1 and next state RUN.
- MEM_WAIT:
  - All enables 0 and no flush until exit. Wait counter increments each cycle.
  - When mem_ready=1: the cycle behaves as RUN with mw=0, with the full priority applied. Next state follows the RUN rules.
  - When wait counter == MEM_TIMEOUT and mem_ready=0: set mem_timeout=1. That cycle behaves as mem_ready=1 (access aborted, pipeline advances).
- Counters saturate at 2^CNT_WIDTH-1 and do not wrap. They are cleared only by reset.
- mem_timeout is cleared only by reset.
- Reset mid MEM_WAIT or mid FLUSH aborts immediately to RUN. The reset-cycle outputs are as specified above.

Decomposition:
- Shared package `pipeline_ctrl_pkg`:
  - State encodings RUN/FLUSH/MEM_WAIT.
  - 3-bit register-index width.
- One sub-module `hazard_match`: combinational four-way compare producing lu, so the comparator can be unit-tested.
- Counters are inline.

Test Plan:
1. Reset low 2 cycles, then high with no events → state=0, pc_write=1, all regWrite=1, counters 0.
2. p2_memRead=1, p2_mem_regWrite=1, p2_mem_rd=3, p1_alu_rn=3, useRn=1 → in the same cycle pc_write=0, p1_pipeline_regWrite=0, p2_pipeline_stall=1. Next cycle, with p2_memRead=0, normal operation; loaduse_count=1.
3. p2_isBranch=1, branch_taken=1, with the lu condition of test 2 also true → IF_flush=ID_flush=1, no stall. state=1 next cycle, then 0; flush_count=1, loaduse_count unchanged.
4. p3_memAccess=1, mem_ready=0 for 4 cycles, then 1 → enables 0 for 4 cycles, state=2. Released on the ready cycle; memwait_count=1.
5. MEM_TIMEOUT=5, mem_ready held 0 → the mem_timeout=1 cycle is the abort cycle where the pipeline advances. mem_timeout stays 1 until reset.
6. Drive 70000 load-use cycles with CNT_WIDTH=16 → loaduse_count saturates at 65535.
